spi_motor_cmd: RTL and testbench
================================

# spi_motor_cmd

Frame-level command decoder between the mbed-facing `spi_slave` byte interface and the five `BLDC_Motor` instances. It assembles received bytes into command frames and commits duty cycle, direction and drive mode for each motor only when a complete, well-formed frame ends. At each frame start it snapshots the encoder and hall counters and serves them back as the transmit byte stream. A saturating watchdog forces all motors off when no valid command arrives.

## Interface
Parameters:
- `LOGIC_VERSION`, 8'h05: transmit byte 0 of every frame.
- `WDT_WIDTH`, 22: watchdog counter width.

Ports:
- `sysclk`  in  1  system clock, 18.432 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `frame_start`  in  1  one-cycle strobe when ncs is asserted.
- `frame_end`  in  1  one-cycle strobe when ncs is released.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a complete received byte.
- `rx_data`  in  8  received byte.
- `tx_load`  in  1  one-cycle strobe: the slave needs the next transmit byte.
- `tx_data`  out  8  byte to transmit, registered.
- `enc_count`  in  80  5×16 encoder counts. Motor m occupies [16m+15:16m]. Motor 4 has no encoder and its slice is ignored.
- `hall_count`  in  40  5×8 hall counts.
- `hall_fault`  in  5  per-motor fault flags.
- `duty_cycle`  out  45  5×9 magnitudes.
- `motor_dir`  out  5  direction per motor.
- `drive_mode`  out  10  5×2 modes.
- `wdt_overflow_count`  out  8  saturating count of watchdog trips.

## Operation
- Reset: `tx_data` = `LOGIC_VERSION`. `duty_cycle`, `motor_dir`, `drive_mode` and `wdt_overflow_count` = 0. Byte index = 0. Watchdog = 0. All captures = 0.
- Byte index: 5-bit, cleared by `frame_start`, incremented on each `rx_valid`, saturates at 31.
  - The byte at index 0 is latched as `cmd`.
  - Bytes at indexes 1..10 go to `rx_buf[idx-1]`.
  - Bytes beyond index 10 are counted but not stored.
- Frame start:
  - Capture `enc_count[63:0]`, `hall_count` and `hall_fault` into snapshot registers.
  - Set `tx_data` = `LOGIC_VERSION`.
  - `cmd` is reset to 8'hFF.
- Transmit: on `tx_load`, the transmit index is the current byte index, i.e. the number of bytes already received.
  - `cmd` 8'h00, index 1–8: encoder snapshot m, low byte then high byte.
  - `cmd` 8'h00, index 9: {3'b0, fault}.
  - `cmd` 8'h00, index 10–14: hall snapshot 0–4.
  - `cmd` 8'h00, any other index: 8'h00.
  - `cmd` 8'h01, index 1: `wdt_overflow_count`.
  - `cmd` 8'h01, any other index: 8'h00.
  - Any other `cmd`: 8'hEE.
- Commit: on `frame_end` with `cmd` == 8'h01 and byte index == 11 exactly, for each motor m:
  - `duty_cycle[m]` = {`rx_buf[2m+1][0]`, `rx_buf[2m]`}.
  - `motor_dir[m]` = `rx_buf[2m+1][1]`.
  - `drive_mode[m]` = `rx_buf[2m+1][3:2]`.
  - The watchdog is cleared.
  - Any other byte count, or any other `cmd`, changes nothing; the watchdog keeps counting.
- Watchdog: increments every cycle and saturates at all-ones (it never wraps).
  - When it reaches all-ones−1, `wdt_overflow_count` increments once, saturating at 255.
  - While at all-ones, `duty_cycle`, `motor_dir` and `drive_mode` are forced to 0 every cycle.
- Simultaneous events:
  - `frame_start` with `rx_valid`: the start is applied first, and the byte is treated as byte 0.
  - `frame_end` with `rx_valid`: the byte is counted first, then the commit check uses the updated index.
  - A commit on the same cycle as watchdog saturation: the commit wins.
  - `frame_start` without a prior `frame_end`: the partial frame is discarded silently.
- Reset mid-frame: the partial frame is lost and the outputs take their reset values.

## Timing
- `tx_data` is valid on the cycle after `tx_load`. The slave must not shift before then, which is guaranteed because SCK ≤ sysclk/8.
- Commit latency: outputs update on the cycle after `frame_end`.
- Snapshot values are taken on the `frame_start` cycle and are stable for the whole frame.
- Watchdog timeout is 2^WDT_WIDTH−1 cycles after the last commit, about 227 ms at the default width.

## Structure
- Shared package `robocup_pkg` holds:
  - `CMD_STATUS`=8'h00, `CMD_MOTOR_SET`=8'h01, `CMD_INVALID_RSP`=8'hEE.
  - `NUM_MOTORS`=5, `NUM_ENCODERS`=4.
  - `DUTY_WIDTH`=9 and the frame length, 11.
- One natural sub-module, `watchdog_sat`: a saturating counter with `clear`, `pre_trip` and `tripped` outputs.
- The remainder is a single always block for byte and frame logic plus a transmit mux.

## Test plan
- Motor-set commit: frame 01, then motor m bytes {m+0x10, 0x07}, then frame_end → duty_cycle[m] = 0x100|(m+0x10), motor_dir[m] = 1, drive_mode[m] = 2'b01, watchdog = 0.
- Short and long frames: 10 bytes, then 12 bytes, each with `cmd` 01 → outputs unchanged from the prior valid values.
- Status readback: encoder 0 = 16'hBEEF and hall 2 = 8'h5A at frame_start, `cmd` 00 → tx sequence 05, EF, BE, …, with index 12 = 5A. Counters changing mid-frame do not alter the bytes.
- Watchdog (WDT_WIDTH=6): with no commits, after 63 cycles → all outputs 0 and `wdt_overflow_count` = 1. Holding 300 more cycles → count stays 1. A commit then restarts the timer.
- Invalid `cmd` 8'h42 → tx bytes 1..n = EE and no commit at frame_end.
- Reset asserted mid-frame after 5 bytes, then a full valid frame → only the second frame commits.

Source files
------------

// File: rtl/robocup_pkg.sv
// Shared constants and helpers for the mbed-facing command path.
// Frame layout: byte 0 is the command, bytes 1..10 carry per-motor payloads.
package robocup_pkg;

  localparam logic [7:0] CMD_STATUS      = 8'h00;
  localparam logic [7:0] CMD_MOTOR_SET   = 8'h01;
  localparam logic [7:0] CMD_INVALID_RSP = 8'hEE;

  localparam int NUM_MOTORS   = 5;
  localparam int NUM_ENCODERS = 4;
  localparam int DUTY_WIDTH   = 9;
  localparam int FRAME_LEN    = 11;
  localparam int RX_BUF_LEN   = FRAME_LEN - 1;

  typedef struct packed {
    logic [DUTY_WIDTH-1:0] duty;
    logic                  dir;
    logic [1:0]            mode;
  } motor_cmd_t;

  // Two payload bytes per motor: lo = duty[7:0]; hi = {mode, dir, duty[8]} in bits [3:0].
  function automatic motor_cmd_t decode_motor(input logic [7:0] lo, input logic [7:0] hi);
    motor_cmd_t mc;
    mc.duty = {hi[0], lo};
    mc.dir  = hi[1];
    mc.mode = hi[3:2];
    return mc;
  endfunction

endpackage

// File: rtl/watchdog_sat.sv
// Saturating watchdog counter: counts up every cycle, sticks at all-ones,
// restarts from zero on clear.
module watchdog_sat #(
  parameter int WIDTH = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic pre_trip,
  output logic tripped
);

  localparam logic [WIDTH-1:0] PRE_TRIP_VAL = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!tripped) begin
      count <= count + 1'b1;
    end
  end

  assign tripped  = &count;
  assign pre_trip = (count == PRE_TRIP_VAL);

endmodule

// File: rtl/spi_motor_cmd.sv
// Frame-level command decoder between the SPI slave byte stream and the motor drivers.
// Commits motor settings only on a complete motor-set frame and serves status snapshots.
module spi_motor_cmd
  import robocup_pkg::*;
#(
  parameter logic [7:0] LOGIC_VERSION = 8'h05,
  parameter int         WDT_WIDTH     = 22
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_load,
  output logic [7:0]  tx_data,
  input  logic [79:0] enc_count,
  input  logic [39:0] hall_count,
  input  logic [4:0]  hall_fault,
  output logic [44:0] duty_cycle,
  output logic [4:0]  motor_dir,
  output logic [9:0]  drive_mode,
  output logic [7:0]  wdt_overflow_count
);

  localparam int ENC_BITS  = 16 * NUM_ENCODERS;
  localparam int HALL_BITS = 8 * NUM_MOTORS;
  localparam logic [4:0] IDX_MAX = 5'h1F;

  logic [4:0]           byte_idx, byte_idx_n;
  logic [7:0]           cmd, cmd_n;
  logic [7:0]           rx_buf   [RX_BUF_LEN];
  logic [7:0]           rx_buf_n [RX_BUF_LEN];
  logic [3:0]           wr_sel;
  logic                 commit;

  logic [ENC_BITS-1:0]  enc_snap;
  logic [HALL_BITS-1:0] hall_snap;
  logic [4:0]           fault_snap;
  logic [2:0]           enc_sel, hall_sel;
  logic [7:0]           tx_byte;

  logic [44:0]          duty_set;
  logic [4:0]           dir_set;
  logic [9:0]           mode_set;

  logic                 wdt_pre_trip, wdt_tripped;
  logic                 unused_enc_hi;

  // Motor 4 has no encoder; its count slice is intentionally dropped.
  assign unused_enc_hi = ^enc_count[79:ENC_BITS];

  // Next frame state: a start applies before a same-cycle byte, and a
  // same-cycle byte is counted before the end-of-frame commit check.
  always_comb begin
    byte_idx_n = byte_idx;
    cmd_n      = cmd;
    rx_buf_n   = rx_buf;
    wr_sel     = '0;
    if (frame_start) begin
      byte_idx_n = '0;
      cmd_n      = 8'hFF;
    end
    if (rx_valid) begin
      wr_sel = byte_idx_n[3:0] - 4'd1;
      if (byte_idx_n == 5'd0) begin
        cmd_n = rx_data;
      end else if (byte_idx_n <= 5'(RX_BUF_LEN)) begin
        rx_buf_n[wr_sel] = rx_data;
      end
      if (byte_idx_n != IDX_MAX) begin
        byte_idx_n = byte_idx_n + 5'd1;
      end
    end
    commit = frame_end && (cmd_n == CMD_MOTOR_SET) && (byte_idx_n == 5'(FRAME_LEN));
  end

  always_comb begin
    motor_cmd_t mc;
    mc       = '0;
    duty_set = '0;
    dir_set  = '0;
    mode_set = '0;
    for (int m = 0; m < NUM_MOTORS; m++) begin
      mc = decode_motor(rx_buf_n[2*m], rx_buf_n[2*m+1]);
      duty_set[DUTY_WIDTH*m +: DUTY_WIDTH] = mc.duty;
      dir_set[m]                           = mc.dir;
      mode_set[2*m +: 2]                   = mc.mode;
    end
  end

  // Index 1..8 walks the encoder snapshot bytewise; 10..14 walks the hall snapshot.
  assign enc_sel  = byte_idx[2:0] - 3'd1;
  assign hall_sel = byte_idx[2:0] - 3'd2;

  always_comb begin
    tx_byte = 8'h00;
    case (cmd)
      CMD_STATUS: begin
        if (byte_idx >= 5'd1 && byte_idx <= 5'd8) begin
          tx_byte = enc_snap[{enc_sel, 3'b000} +: 8];
        end else if (byte_idx == 5'd9) begin
          tx_byte = {3'b000, fault_snap};
        end else if (byte_idx >= 5'd10 && byte_idx <= 5'd14) begin
          tx_byte = hall_snap[{hall_sel, 3'b000} +: 8];
        end
      end
      CMD_MOTOR_SET: begin
        if (byte_idx == 5'd1) begin
          tx_byte = wdt_overflow_count;
        end
      end
      default: tx_byte = CMD_INVALID_RSP;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      byte_idx           <= '0;
      cmd                <= '0;
      rx_buf             <= '{default: '0};
      enc_snap           <= '0;
      hall_snap          <= '0;
      fault_snap         <= '0;
      tx_data            <= LOGIC_VERSION;
      duty_cycle         <= '0;
      motor_dir          <= '0;
      drive_mode         <= '0;
      wdt_overflow_count <= '0;
    end else begin
      byte_idx <= byte_idx_n;
      cmd      <= cmd_n;
      rx_buf   <= rx_buf_n;

      if (frame_start) begin
        enc_snap   <= enc_count[ENC_BITS-1:0];
        hall_snap  <= hall_count;
        fault_snap <= hall_fault;
        tx_data    <= LOGIC_VERSION;
      end else if (tx_load) begin
        tx_data <= tx_byte;
      end

      // A commit landing on the saturated cycle still takes effect.
      if (commit) begin
        duty_cycle <= duty_set;
        motor_dir  <= dir_set;
        drive_mode <= mode_set;
      end else if (wdt_tripped) begin
        duty_cycle <= '0;
        motor_dir  <= '0;
        drive_mode <= '0;
      end

      if (wdt_pre_trip && (wdt_overflow_count != 8'hFF)) begin
        wdt_overflow_count <= wdt_overflow_count + 8'd1;
      end
    end
  end

  watchdog_sat #(
    .WIDTH(WDT_WIDTH)
  ) u_wdt (
    .clk     (sysclk),
    .rst     (rst),
    .clear   (commit),
    .pre_trip(wdt_pre_trip),
    .tripped (wdt_tripped)
  );

endmodule

// File: tb/tb_spi_motor_cmd.sv
// Bench for spi_motor_cmd: directed vector table and corner sequences, then
// randomized frames compared each cycle against a frame-level reference model.
module tb_spi_motor_cmd;

  localparam int         WDT_W   = 6;
  localparam int         WDT_MAX = (1 << WDT_W) - 1;
  localparam logic [7:0] VER     = 8'h05;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0, frame_end = 1'b0, rx_valid = 1'b0, tx_load = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [79:0] enc_count = '0;
  logic [39:0] hall_count = '0;
  logic [4:0]  hall_fault = '0;
  logic [7:0]  tx_data;
  logic [44:0] duty_cycle;
  logic [4:0]  motor_dir;
  logic [9:0]  drive_mode;
  logic [7:0]  wdt_overflow_count;

  int n_checks = 0;
  int n_pass   = 0;

  spi_motor_cmd #(.LOGIC_VERSION(VER), .WDT_WIDTH(WDT_W)) dut (
    .sysclk(sysclk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_load(tx_load), .tx_data(tx_data),
    .enc_count(enc_count), .hall_count(hall_count), .hall_fault(hall_fault),
    .duty_cycle(duty_cycle), .motor_dir(motor_dir), .drive_mode(drive_mode),
    .wdt_overflow_count(wdt_overflow_count)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: bytes of the current frame, snapshots, committed outputs,
  // and the number of cycles since the last commit (capped at WDT_MAX).
  logic [7:0]  mq[$];
  logic [7:0]  m_cmd_def;
  logic [15:0] m_enc[4];
  logic [7:0]  m_hall[5];
  logic [4:0]  m_fault;
  logic [44:0] m_duty;
  logic [4:0]  m_dir;
  logic [9:0]  m_mode;
  logic [7:0]  m_tx;
  int          m_ovf;
  int          m_age;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cmd_def = 8'h00;
    for (int k = 0; k < 4; k++) m_enc[k] = '0;
    for (int k = 0; k < 5; k++) m_hall[k] = '0;
    m_fault = '0; m_duty = '0; m_dir = '0; m_mode = '0;
    m_tx = VER; m_ovf = 0; m_age = 0;
  endtask

  function automatic logic [7:0] tx_model();
    int i;
    logic [7:0]  c;
    logic [15:0] w;
    i = (mq.size() > 31) ? 31 : mq.size();
    c = (mq.size() > 0) ? mq[0] : m_cmd_def;
    if (c == 8'h00) begin
      if (i >= 1 && i <= 8) begin
        w = m_enc[(i - 1) / 2];
        return (i % 2 == 1) ? w[7:0] : w[15:8];
      end
      if (i == 9) return {3'b000, m_fault};
      if (i >= 10 && i <= 14) return m_hall[i - 10];
      return 8'h00;
    end
    if (c == 8'h01) return (i == 1) ? m_ovf[7:0] : 8'h00;
    return 8'hEE;
  endfunction

  task automatic model_step();
    bit commit;
    logic [7:0] lo, hi;
    if (rst) begin
      model_reset();
      return;
    end
    if (frame_start) m_tx = VER;
    else if (tx_load) m_tx = tx_model();
    if (frame_start) begin
      mq.delete();
      m_cmd_def = 8'hFF;
      for (int k = 0; k < 4; k++) m_enc[k] = enc_count[16*k +: 16];
      for (int k = 0; k < 5; k++) m_hall[k] = hall_count[8*k +: 8];
      m_fault = hall_fault;
    end
    if (rx_valid) mq.push_back(rx_data);
    commit = frame_end && (mq.size() == 11) && (mq[0] == 8'h01);
    if (commit) begin
      for (int m = 0; m < 5; m++) begin
        lo = mq[1 + 2*m];
        hi = mq[2 + 2*m];
        m_duty[9*m +: 9] = {hi[0], lo};
        m_dir[m]         = hi[1];
        m_mode[2*m +: 2] = hi[3:2];
      end
    end else if (m_age == WDT_MAX) begin
      m_duty = '0; m_dir = '0; m_mode = '0;
    end
    if (m_age == WDT_MAX - 1 && m_ovf < 255) m_ovf++;
    m_age = commit ? 0 : ((m_age < WDT_MAX) ? m_age + 1 : WDT_MAX);
  endtask

  task automatic step();
    @(posedge sysclk);
    model_step();
    #1;
    check("model_motor_outputs", {duty_cycle, motor_dir, drive_mode}, {m_duty, m_dir, m_mode});
    check("model_wdt_overflow", wdt_overflow_count, m_ovf[7:0]);
    check("model_tx_data", tx_data, m_tx);
    frame_start = 1'b0; frame_end = 1'b0; rx_valid = 1'b0; tx_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    step();
  endtask

  task automatic load_tx();
    tx_load = 1'b1;
    step();
  endtask

  task automatic send_frame(input logic [7:0] fb[$], input bit merge_start, input bit merge_end);
    int first;
    first = 0;
    frame_start = 1'b1;
    if (merge_start && fb.size() > 0) begin
      rx_valid = 1'b1; rx_data = fb[0]; first = 1;
    end
    step();
    for (int i = first; i < fb.size(); i++) begin
      rx_valid = 1'b1; rx_data = fb[i];
      if (merge_end && i == fb.size() - 1) frame_end = 1'b1;
      step();
    end
    if (!merge_end || fb.size() == 0) begin
      frame_end = 1'b1;
      step();
    end
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [8:0] duty;
    logic       dir;
    logic [1:0] mode;
  } vec_t;
  vec_t tbl[5];

  task automatic commit_rec(input int r, input bit ms, input bit me);
    logic [7:0] fb[$];
    fb.push_back(8'h01);
    for (int m = 0; m < 5; m++) begin
      fb.push_back(tbl[r].lo);
      fb.push_back(tbl[r].hi);
    end
    send_frame(fb, ms, me);
  endtask

  task automatic check_rec(input string name, input int r);
    check({name, "_duty"}, duty_cycle, {5{tbl[r].duty}});
    check({name, "_dir"},  motor_dir,  {5{tbl[r].dir}});
    check({name, "_mode"}, drive_mode, {5{tbl[r].mode}});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  fb[$];
    logic [7:0]  rb[16];
    logic [44:0] exp_duty;

    tbl[0] = '{8'h10, 8'h07, 9'h110, 1'b1, 2'b01};
    tbl[1] = '{8'hFF, 8'h00, 9'h0FF, 1'b0, 2'b00};
    tbl[2] = '{8'h00, 8'h01, 9'h100, 1'b0, 2'b00};
    tbl[3] = '{8'h5A, 8'h0E, 9'h05A, 1'b1, 2'b11};
    tbl[4] = '{8'hA5, 8'hF9, 9'h1A5, 1'b0, 2'b10};

    // Reset state
    rst = 1'b1;
    idle(2);
    check("reset_tx", tx_data, VER);
    check("reset_duty", duty_cycle, 45'd0);
    check("reset_dir_mode", {motor_dir, drive_mode}, 15'd0);
    check("reset_ovf", wdt_overflow_count, 8'd0);
    rst = 1'b0;

    for (int r = 0; r < 5; r++) begin
      commit_rec(r, 1'b0, 1'b0);
      check_rec("tbl", r);
    end

    // Motor m bytes {m+0x10, 0x07}; first byte with start, last with end
    fb.delete();
    fb.push_back(8'h01);
    for (int m = 0; m < 5; m++) begin
      fb.push_back(8'(m + 16));
      fb.push_back(8'h07);
    end
    send_frame(fb, 1'b1, 1'b1);
    for (int m = 0; m < 5; m++) exp_duty[9*m +: 9] = 9'h100 | 9'(m + 16);
    check("plan_duty", duty_cycle, exp_duty);
    check("plan_dir", motor_dir, 5'b11111);
    check("plan_mode", drive_mode, {5{2'b01}});

    // Short (10 bytes) and long (12 bytes) frames leave outputs alone
    fb.delete();
    fb.push_back(8'h01);
    for (int i = 0; i < 9; i++) fb.push_back(8'hC3);
    send_frame(fb, 1'b0, 1'b0);
    check("short_frame_duty", duty_cycle, exp_duty);
    fb.push_back(8'hC3);
    fb.push_back(8'hC3);
    send_frame(fb, 1'b0, 1'b0);
    check("long_frame_duty", duty_cycle, exp_duty);
    check("long_frame_mode", drive_mode, {5{2'b01}});

    // Status readback; counters change after the snapshot
    enc_count  = {16'hDEAD, 16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
    hall_count = {8'h44, 8'h33, 8'h5A, 8'h11, 8'h10};
    hall_fault = 5'b10110;
    frame_start = 1'b1;
    step();
    check("status_byte0", tx_data, VER);
    enc_count  = {5{16'h7777}};
    hall_count = {5{8'h99}};
    hall_fault = 5'b01001;
    for (int i = 1; i <= 15; i++) begin
      send_byte(i == 1 ? 8'h00 : 8'(i));
      load_tx();
      rb[i] = tx_data;
    end
    frame_end = 1'b1;
    step();
    check("status_enc0_lo", rb[1], 8'hEF);
    check("status_enc0_hi", rb[2], 8'hBE);
    check("status_enc3_lo", rb[7], 8'h33);
    check("status_fault", rb[9], 8'h16);
    check("status_hall2", rb[12], 8'h5A);
    check("status_hall4", rb[14], 8'h44);
    check("status_past_end", rb[15], 8'h00);

    // Invalid command: EE responses, no commit
    commit_rec(0, 1'b0, 1'b0);
    frame_start = 1'b1;
    step();
    send_byte(8'h42);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h3C);
      if (i == 2) begin
        load_tx();
        check("invalid_tx", tx_data, 8'hEE);
      end
    end
    frame_end = 1'b1;
    step();
    check_rec("invalid_no_commit", 0);

    // Watchdog trip, hold, and restart
    rst = 1'b1;
    step();
    rst = 1'b0;
    commit_rec(0, 1'b0, 1'b0);
    idle(WDT_MAX - 1);
    check("wdt_before_trip_duty", duty_cycle, {5{9'h110}});
    check("wdt_before_trip_ovf", wdt_overflow_count, 8'd0);
    idle(2);
    check("wdt_tripped_outputs", {duty_cycle, motor_dir, drive_mode}, 60'd0);
    check("wdt_tripped_ovf", wdt_overflow_count, 8'd1);
    idle(300);
    check("wdt_hold_ovf", wdt_overflow_count, 8'd1);
    check("wdt_hold_outputs", {duty_cycle, motor_dir, drive_mode}, 60'd0);
    frame_start = 1'b1;
    step();
    send_byte(8'h01);
    load_tx();
    check("motor_set_tx_ovf", tx_data, 8'h01);
    for (int m = 0; m < 5; m++) begin
      send_byte(tbl[3].lo);
      send_byte(tbl[3].hi);
    end
    frame_end = 1'b1;
    step();
    check_rec("wdt_commit_while_tripped", 3);
    idle(WDT_MAX - 1);
    check_rec("wdt_restarted", 3);
    check("wdt_restarted_ovf", wdt_overflow_count, 8'd1);

    // Reset in the middle of a frame
    frame_start = 1'b1;
    step();
    send_byte(8'h01);
    for (int i = 0; i < 2; i++) begin
      send_byte(tbl[0].lo);
      send_byte(tbl[0].hi);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midframe_reset_duty", duty_cycle, 45'd0);
    check("midframe_reset_tx", tx_data, VER);
    for (int i = 0; i < 3; i++) begin
      send_byte(tbl[0].lo);
      send_byte(tbl[0].hi);
    end
    frame_end = 1'b1;
    step();
    check("midframe_tail_no_commit", duty_cycle, 45'd0);
    commit_rec(4, 1'b0, 1'b0);
    check_rec("after_reset_commit", 4);

    // Randomized frames against the reference model
    for (int f = 0; f < 80; f++) begin
      int nb;
      int r;
      int first;
      bit ended;
      logic [7:0] c;
      enc_count  = {16'($urandom), 32'($urandom), 32'($urandom)};
      hall_count = {8'($urandom), 32'($urandom)};
      hall_fault = 5'($urandom);
      r  = $urandom_range(0, 9);
      nb = (r < 6) ? 11 : (r == 6) ? 10 : (r == 7) ? 12 : $urandom_range(0, 16);
      r  = $urandom_range(0, 9);
      c  = (r < 6) ? 8'h01 : (r < 9) ? 8'h00 : 8'($urandom);
      first = 0;
      ended = 1'b0;
      frame_start = 1'b1;
      if (nb > 0 && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b1; rx_data = c; first = 1;
      end
      step();
      for (int b = first; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin
          tx_load = ($urandom_range(0, 1) == 1);
          if ($urandom_range(0, 7) == 0) enc_count = {16'($urandom), 32'($urandom), 32'($urandom)};
          step();
        end
        rx_valid = 1'b1;
        rx_data  = (b == 0) ? c : 8'($urandom);
        tx_load  = ($urandom_range(0, 5) == 0);
        if (b == nb - 1 && $urandom_range(0, 2) == 0) begin
          frame_end = 1'b1; ended = 1'b1;
        end
        step();
      end
      if (!ended) begin
        frame_end = 1'b1;
        step();
      end
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle(70);
    end

    // Overflow count saturates at 255
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int t = 0; t < 258; t++) begin
      commit_rec(1, 1'b1, 1'b1);
      idle(WDT_MAX + 1);
    end
    check("ovf_saturates", wdt_overflow_count, 8'd255);
    check("ovf_saturated_outputs", duty_cycle, 45'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
